// File: rtl/reg_access_seq_pkg.sv
// reg_access_seq_pkg: opcode constants and sequencer state encoding
package reg_access_seq_pkg;
  localparam logic [1:0] OP_LI  = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4,
    DONE = 3'd5
  } state_t;
endpackage

// File: rtl/seq_alu.sv
// seq_alu: 8-bit add/sub with carry-out or borrow and zero flag
module seq_alu (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sub,
  output logic [7:0] y,
  output logic       c,
  output logic       z
);
  logic [8:0] r;
  assign r = sub ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
  assign y = r[7:0];
  assign c = r[8];
  assign z = ~|r[7:0];
endmodule

// File: rtl/reg_access_seq.sv
// reg_access_seq: register-bank access sequencer for LI/MOV/ADD/SUB
module reg_access_seq
  import reg_access_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  input  logic [7:0] imm,
  output logic       instr_ready,
  output logic       WR,
  output logic [1:0] rd,
  output logic [1:0] rs,
  output logic [7:0] data,
  input  logic [7:0] regVal,
  output logic       done,
  output logic       zero,
  output logic       carry
);
  state_t state;
  logic [1:0] op, dst, src;
  logic [7:0] op_a, op_b, alu_y;
  logic alu_c, alu_z;
  logic unused_rsvd;
  assign unused_rsvd = ^instr[1:0];
  assign instr_ready = state == IDLE;
  // MOV passes opA through the adder with a zero second operand
  seq_alu u_alu (
    .a(op_a),
    .b(op == OP_MOV ? 8'd0 : op_b),
    .sub(op == OP_SUB),
    .y(alu_y),
    .c(alu_c),
    .z(alu_z)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      WR    <= 1'b0;
      done  <= 1'b0;
      rd    <= 2'd0;
      rs    <= 2'd0;
      data  <= 8'd0;
      zero  <= 1'b0;
      carry <= 1'b0;
      op_a  <= 8'd0;
      op_b  <= 8'd0;
      op    <= OP_LI;
      dst   <= 2'd0;
      src   <= 2'd0;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          op  <= instr[7:6];
          dst <= instr[5:4];
          src <= instr[3:2];
          if (instr[7:6] == OP_LI) begin
            state <= WB;
            WR    <= 1'b1;
            rd    <= instr[5:4];
            data  <= imm;
          end else begin
            state <= RDA;
            rs    <= instr[7:6] == OP_MOV ? instr[3:2] : instr[5:4];
          end
        end
        RDA: begin
          op_a <= regVal;
          if (op == OP_MOV) state <= EXEC;
          else begin
            state <= RDB;
            rs    <= src;
          end
        end
        RDB: begin
          op_b  <= regVal;
          state <= EXEC;
        end
        EXEC: begin
          state <= WB;
          WR    <= 1'b1;
          rd    <= dst;
          data  <= alu_y;
        end
        WB: begin
          state <= DONE;
          WR    <= 1'b0;
          done  <= 1'b1;
          if (op[1]) begin
            zero  <= alu_z;
            carry <= alu_c;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_access_seq.sv
// tb_reg_access_seq: directed bench with a behavioural 4x8 register bank
module tb_reg_access_seq;
  logic clock = 1'b0, reset_n = 1'b0, instr_valid = 1'b0;
  logic [7:0] instr = 8'd0, imm = 8'd0, data, regVal = 8'd0;
  logic instr_ready, WR, done, zero, carry;
  logic [1:0] rd, rs;
  logic [7:0] bank [4];
  int n_chk = 0, n_pass = 0;
  int wr_cyc, done_cyc;
  logic [1:0] wr_rd;
  logic [7:0] wr_data;
  reg_access_seq dut (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr(instr),
    .imm(imm), .instr_ready(instr_ready), .WR(WR), .rd(rd), .rs(rs),
    .data(data), .regVal(regVal), .done(done), .zero(zero), .carry(carry)
  );
  always #5 clock = ~clock;
  always @(posedge clock) if (WR) bank[rd] <= data;
  always @(negedge clock) regVal <= bank[rs];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  // returns at #1 after the accept edge, i.e. in cycle 1 of the instruction
  task automatic start(input logic [1:0] op, input logic [1:0] d, input logic [1:0] s, input logic [7:0] v);
    int g = 0;
    instr = {op, d, s, 2'b10};
    imm = v;
    instr_valid = 1'b1;
    @(negedge clock);
    while (!instr_ready && g < 20) begin
      @(negedge clock);
      g++;
    end
    @(posedge clock);
    #1 instr_valid = 1'b0;
  endtask
  task automatic watch();
    wr_cyc = 0;
    done_cyc = 0;
    wr_rd = 2'd0;
    wr_data = 8'd0;
    for (int k = 1; k <= 10; k++) begin
      if (WR && wr_cyc == 0) begin
        wr_cyc = k;
        wr_rd = rd;
        wr_data = data;
      end
      if (done) begin
        done_cyc = k;
        break;
      end
      @(posedge clock);
      #1;
    end
  endtask
  task automatic exec(input logic [1:0] op, input logic [1:0] d, input logic [1:0] s, input logic [7:0] v);
    start(op, d, s, v);
    watch();
  endtask
  initial begin
    int li_cyc;
    logic wr_seen;
    for (int i = 0; i < 4; i++) bank[i] = 8'd0;
    #12;
    check("rst_ready", instr_ready, 1);
    check("rst_wr", WR, 0);
    check("rst_done", done, 0);
    check("rst_idx", {rd, rs}, 0);
    check("rst_flags", {zero, carry}, 0);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    #1 check("ready_after_rst", instr_ready, 1);
    exec(2'b00, 2'd2, 2'd0, 8'h5A);
    check("li_wr_lat", wr_cyc, 1);
    check("li_wr_rd", wr_rd, 2);
    check("li_wr_data", wr_data, 8'h5A);
    check("li_done_lat", done_cyc, 2);
    check("li_r2", bank[2], 8'h5A);
    exec(2'b00, 2'd0, 2'd0, 8'h03);
    exec(2'b00, 2'd1, 2'd0, 8'h04);
    exec(2'b10, 2'd0, 2'd1, 8'h00);
    check("add_wr_lat", wr_cyc, 4);
    check("add_done_lat", done_cyc, 5);
    check("add_r0", bank[0], 8'h07);
    check("add_flags", {zero, carry}, 2'b00);
    exec(2'b00, 2'd0, 2'd0, 8'hFF);
    exec(2'b00, 2'd1, 2'd0, 8'h01);
    exec(2'b10, 2'd0, 2'd1, 8'h00);
    check("wrap_r0", bank[0], 8'h00);
    check("wrap_flags", {zero, carry}, 2'b11);
    exec(2'b00, 2'd3, 2'd0, 8'h10);
    exec(2'b11, 2'd3, 2'd3, 8'h00);
    check("subself_done_lat", done_cyc, 5);
    check("subself_r3", bank[3], 8'h00);
    check("subself_flags", {zero, carry}, 2'b10);
    exec(2'b11, 2'd3, 2'd1, 8'h00);
    check("borrow_r3", bank[3], 8'hFF);
    check("borrow_flags", {zero, carry}, 2'b01);
    exec(2'b01, 2'd2, 2'd3, 8'h00);
    check("mov_wr_lat", wr_cyc, 3);
    check("mov_done_lat", done_cyc, 4);
    check("mov_r2", bank[2], 8'hFF);
    check("mov_flags_held", {zero, carry}, 2'b01);
    // second instruction offered while ADD r0=r0+r1 (0+1) is in flight
    start(2'b10, 2'd0, 2'd1, 8'h00);
    instr = {2'b00, 2'd2, 2'd0, 2'b01};
    imm = 8'h77;
    instr_valid = 1'b1;
    li_cyc = 0;
    wr_cyc = 0;
    wr_data = 8'd0;
    for (int k = 1; k <= 12; k++) begin
      if (WR && rd == 2'd0 && wr_cyc == 0) begin
        wr_cyc = k;
        wr_data = data;
      end
      if (WR && rd == 2'd2 && li_cyc == 0) begin
        li_cyc = k;
        instr_valid = 1'b0;
      end
      if (k == 3) check("busy_ready", instr_ready, 0);
      @(posedge clock);
      #1;
    end
    instr_valid = 1'b0;
    check("busy_add_wr_lat", wr_cyc, 4);
    check("busy_add_data", wr_data, 8'h01);
    check("busy_li_wr_lat", li_cyc, 7);
    check("busy_r0", bank[0], 8'h01);
    check("busy_r2", bank[2], 8'h77);
    // reset during RDB of ADD r0=r0+r1
    start(2'b10, 2'd0, 2'd1, 8'h00);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("abort_wr", WR, 0);
    check("abort_done", done, 0);
    check("abort_idx", {rd, rs}, 0);
    check("abort_data", data, 0);
    check("abort_flags", {zero, carry}, 0);
    check("abort_ready", instr_ready, 1);
    wr_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1 wr_seen |= WR;
    end
    @(negedge clock) reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      #1 wr_seen |= WR;
    end
    check("abort_no_wr", wr_seen, 0);
    check("abort_bank", {bank[0], bank[1], bank[2], bank[3]}, 32'h01_01_77_FF);
    exec(2'b00, 2'd1, 2'd0, 8'hAA);
    check("post_rst_li", bank[1], 8'hAA);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
